// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory read channel plus the decoder-side
// instruction stream and jump redirect.
interface instr_fetch_unit_if #(
    parameter int INSTR_W = 19,
    parameter int ADDR_W  = 12
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_ready;
    logic               jump;
    logic [ADDR_W-1:0]  jump_target;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rvalid, imem_rdata,
        output instr_valid, instr, instr_pc,
        input  instr_ready, jump, jump_target
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rvalid, imem_rdata,
        input  instr_valid, instr, instr_pc,
        output instr_ready, jump, jump_target
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: one outstanding memory read, PC-tagged FIFO to the core,
// jump redirect with response kill. Define IFU_PERF_CNT_EN to enable flush_cnt.
module instr_fetch_unit #(
    parameter int                INSTR_W  = 19,
    parameter int                ADDR_W   = 12,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    instr_fetch_unit_if.master     bus,
    output logic [15:0]            flush_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t             state, state_next;
    logic [ADDR_W-1:0]  fetch_pc, fetch_pc_next, req_addr;
    logic [CNT_W-1:0]   count, count_next;
    logic               drop, drop_next;
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [INSTR_W-1:0] fifo_instr [DEPTH];
    logic [ADDR_W-1:0]  fifo_pc    [DEPTH];
    logic               rsp, push, pop, discard, has_space;

    // A jump kills the response arriving in the same cycle and voids any pop.
    assign rsp       = (state == S_WAIT) && bus.imem_rvalid;
    assign discard   = rsp && (drop || bus.jump);
    assign push      = rsp && !drop && !bus.jump;
    assign pop       = bus.instr_valid && bus.instr_ready && !bus.jump;
    assign has_space = count_next < CNT_W'(DEPTH);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        count_next    = count;
        fetch_pc_next = fetch_pc;
        if (bus.jump) begin
            count_next    = '0;
            fetch_pc_next = bus.jump_target;
        end else begin
            if (push) fetch_pc_next = fetch_pc + 1'b1;
            case ({push, pop})
                2'b10:   count_next = count + 1'b1;
                2'b01:   count_next = count - 1'b1;
                default: count_next = count;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        drop_next  = drop;
        case (state)
            S_IDLE: if (has_space) state_next = S_REQ;
            S_REQ: begin
                // The old request must still complete; its response is killed later.
                if (bus.jump) drop_next = 1'b1;
                if (bus.imem_ack) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (rsp) begin
                    drop_next  = 1'b0;
                    state_next = (discard || has_space) ? S_REQ : S_IDLE;
                end else if (bus.jump) begin
                    drop_next = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
            count    <= '0;
            drop     <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            count    <= count_next;
            drop     <= drop_next;
            // Address is captured on entry so a jump cannot move a pending request.
            if (state_next == S_REQ && state != S_REQ) req_addr <= fetch_pc_next;
            if (bus.jump) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // NOTE: FIFO storage is not reset; the output mux hides it while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= bus.imem_rdata;
            fifo_pc[wr_ptr]    <= fetch_pc;
        end
    end

    assign bus.imem_req    = (state == S_REQ);
    assign bus.imem_addr   = req_addr;
    assign bus.instr_valid = (count != '0);
    assign bus.instr       = bus.instr_valid ? fifo_instr[rd_ptr] : '0;
    assign bus.instr_pc    = bus.instr_valid ? fifo_pc[rd_ptr]    : '0;

`ifdef IFU_PERF_CNT_EN
    logic [16:0] flush_sum;

    always_comb begin
        flush_sum = {1'b0, flush_cnt} + 17'(bus.jump ? count : '0) + 17'(discard);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              flush_cnt <= '0;
        else if (flush_sum[16]) flush_cnt <= 16'hFFFF;
        else                   flush_cnt <= flush_sum[15:0];
    end
`else
    assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: cycle table for the streaming/full/jump path,
// then hand sequences for jump corner cases, reset during a fetch and PC wrap.
module tb_instr_fetch_unit;
    logic        clk;
    logic        rst;
    logic [15:0] flush_cnt;
    int          checks = 0;
    int          errors = 0;

    instr_fetch_unit_if #(.INSTR_W(19), .ADDR_W(12)) bus ();

    instr_fetch_unit #(.INSTR_W(19), .ADDR_W(12), .DEPTH(4), .RESET_PC(12'h000)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .flush_cnt (flush_cnt)
    );

`ifdef IFU_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word at address a is a+100; ack after ack_delay waiting
    // cycles, rvalid rsp_delay cycles after ack, one transaction at a time.
    int          ack_delay = 0;
    int          rsp_delay = 1;
    bit          rsp_hold  = 1'b0;
    bit          mem_clear = 1'b0;
    bit          busy      = 1'b0;
    int          ack_wait  = 0;
    int          rsp_cnt   = 0;
    logic [11:0] cap_addr  = '0;
    logic [11:0] pend_addr = '0;

    function automatic logic [18:0] mem_word(input logic [11:0] a);
        return 19'(a) + 19'd100;
    endfunction

    function automatic logic [15:0] exp_flush(input logic [15:0] n);
        return PERF ? n : 16'h0000;
    endfunction

    always @(negedge clk) begin
        bus.imem_rvalid = 1'b0;
        if (mem_clear) begin
            bus.imem_ack   = 1'b0;
            bus.imem_rdata = '0;
            busy           = 1'b0;
            ack_wait       = 0;
        end else begin
            if (bus.imem_ack === 1'b1) begin
                bus.imem_ack = 1'b0;
                busy         = 1'b1;
                rsp_cnt      = rsp_delay;
                pend_addr    = cap_addr;
            end else begin
                bus.imem_ack = 1'b0;
            end
            if (busy && !rsp_hold) begin
                if (rsp_cnt <= 1) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = mem_word(pend_addr);
                    busy            = 1'b0;
                end else begin
                    rsp_cnt--;
                end
            end
            if (bus.imem_req === 1'b1 && !busy) begin
                if (ack_wait >= ack_delay) begin
                    bus.imem_ack = 1'b1;
                    cap_addr     = bus.imem_addr;
                    ack_wait     = 0;
                end else begin
                    ack_wait++;
                end
            end else begin
                ack_wait = 0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        bus.jump        = 1'b0;
        bus.jump_target = '0;
        bus.instr_ready = 1'b0;
        mem_clear       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst       = 1'b1;
        mem_clear = 1'b0;
    endtask

    task automatic wait_req(input logic [11:0] addr, input string name);
        bit found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.imem_req && bus.imem_addr == addr) begin
                found = 1'b1;
                break;
            end
        end
        check(name, 64'(found), 64'd1);
    endtask

    task automatic wait_valid(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.instr_valid) begin
                found = 1'b1;
                break;
            end
        end
        check(name, 64'(found), 64'd1);
    endtask

    typedef struct {
        logic        ready;
        logic        jump;
        logic [11:0] target;
        logic        exp_req;
        logic [11:0] exp_addr;
        logic        exp_valid;
        logic [18:0] exp_instr;
        logic [11:0] exp_pc;
    } vec_t;

    function automatic vec_t vec(input logic r, input logic j, input logic [11:0] t,
                                 input logic q, input logic [11:0] a, input logic v,
                                 input logic [18:0] i, input logic [11:0] p);
        vec_t x;
        x.ready = r; x.jump = j; x.target = t;
        x.exp_req = q; x.exp_addr = a; x.exp_valid = v; x.exp_instr = i; x.exp_pc = p;
        return x;
    endfunction

    vec_t vecs [17];

    initial begin
        // One row per cycle after reset release; address is only compared while requesting.
        vecs[0]  = vec(1'b0, 1'b0, 12'h000, 1'b1, 12'h000, 1'b0, 19'd0,   12'h000);
        vecs[1]  = vec(1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 19'd0,   12'h000);
        vecs[2]  = vec(1'b0, 1'b0, 12'h000, 1'b1, 12'h001, 1'b1, 19'd100, 12'h000);
        vecs[3]  = vec(1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b1, 19'd100, 12'h000);
        vecs[4]  = vec(1'b0, 1'b0, 12'h000, 1'b1, 12'h002, 1'b1, 19'd100, 12'h000);
        vecs[5]  = vec(1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b1, 19'd100, 12'h000);
        vecs[6]  = vec(1'b0, 1'b0, 12'h000, 1'b1, 12'h003, 1'b1, 19'd100, 12'h000);
        vecs[7]  = vec(1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b1, 19'd100, 12'h000);
        vecs[8]  = vec(1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b1, 19'd100, 12'h000);
        vecs[9]  = vec(1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b1, 19'd100, 12'h000);
        vecs[10] = vec(1'b1, 1'b0, 12'h000, 1'b1, 12'h004, 1'b1, 19'd101, 12'h001);
        vecs[11] = vec(1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b1, 19'd101, 12'h001);
        vecs[12] = vec(1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b1, 19'd101, 12'h001);
        vecs[13] = vec(1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b1, 19'd101, 12'h001);
        vecs[14] = vec(1'b0, 1'b1, 12'h123, 1'b1, 12'h123, 1'b0, 19'd0,   12'h000);
        vecs[15] = vec(1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 19'd0,   12'h000);
        vecs[16] = vec(1'b0, 1'b0, 12'h000, 1'b1, 12'h124, 1'b1, 19'h187, 12'h123);

        rst = 1'b0;
        bus.jump        = 1'b0;
        bus.jump_target = '0;
        bus.instr_ready = 1'b0;
        #1;
        check("reset_req",   64'(bus.imem_req),    64'd0);
        check("reset_valid", 64'(bus.instr_valid), 64'd0);
        check("reset_instr", 64'(bus.instr),       64'd0);
        check("reset_pc",    64'(bus.instr_pc),    64'd0);
        check("reset_flush", 64'(flush_cnt),       64'd0);

        // Streaming into a full FIFO, one pop, then a jump from idle.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            bus.instr_ready = vecs[i].ready;
            bus.jump        = vecs[i].jump;
            bus.jump_target = vecs[i].target;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i),
                  {bus.imem_req, (bus.imem_req ? bus.imem_addr : 12'h000),
                   bus.instr_valid, bus.instr, bus.instr_pc},
                  {vecs[i].exp_req, vecs[i].exp_addr, vecs[i].exp_valid,
                   vecs[i].exp_instr, vecs[i].exp_pc});
            @(negedge clk);
        end
        bus.instr_ready = 1'b0;
        bus.jump        = 1'b0;
        check("vec_flush", 64'(flush_cnt), 64'(exp_flush(16'd4)));

        // Jump in S_WAIT (no rvalid) with two entries queued.
        rsp_delay = 3;
        do_reset();
        wait_req(12'h002, "wait_req2");
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        bus.jump = 1'b1; bus.jump_target = 12'h200;
        @(posedge clk); #1;
        check("wj_valid", 64'(bus.instr_valid), 64'd0);
        check("wj_req",   64'(bus.imem_req),    64'd0);
        @(negedge clk);
        bus.jump = 1'b0;
        wait_req(12'h200, "wj_req_target");
        wait_valid("wj_first_valid");
        check("wj_pc",    64'(bus.instr_pc), 64'h200);
        check("wj_instr", 64'(bus.instr),    64'h264);
        check("wj_flush", 64'(flush_cnt),    64'(exp_flush(16'd3)));

        // Jump in S_REQ while memory holds off ack for three cycles.
        rsp_delay = 1;
        ack_delay = 3;
        do_reset();
        @(posedge clk); #1;
        check("rj_req0", {bus.imem_req, bus.imem_addr}, {1'b1, 12'h000});
        @(negedge clk);
        bus.jump = 1'b1; bus.jump_target = 12'h010;
        begin
            bit acked = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                if (!bus.imem_req) begin
                    acked = 1'b1;
                    break;
                end
                check($sformatf("rj_hold_addr%0d", i), 64'(bus.imem_addr), 64'h000);
                @(negedge clk);
                bus.jump = 1'b0;
            end
            check("rj_acked", 64'(acked), 64'd1);
        end
        bus.jump = 1'b0;
        wait_req(12'h010, "rj_req_target");
        wait_valid("rj_first_valid");
        check("rj_pc",    64'(bus.instr_pc), 64'h010);
        check("rj_instr", 64'(bus.instr),    64'h074);
        check("rj_flush", 64'(flush_cnt),    64'(exp_flush(16'd1)));
        ack_delay = 0;

        // Jump coinciding with a pop and an rvalid.
        do_reset();
        wait_req(12'h001, "pj_req1");
        @(negedge clk);
        @(posedge clk); #1;
        check("pj_pre", {bus.instr_valid, bus.instr_pc}, {1'b1, 12'h000});
        @(negedge clk);
        bus.instr_ready = 1'b1;
        bus.jump = 1'b1; bus.jump_target = 12'h040;
        @(posedge clk); #1;
        check("pj_valid", 64'(bus.instr_valid), 64'd0);
        check("pj_req", {bus.imem_req, bus.imem_addr}, {1'b1, 12'h040});
        @(negedge clk);
        bus.jump = 1'b0;
        wait_valid("pj_first_valid");
        check("pj_pc",    64'(bus.instr_pc), 64'h040);
        check("pj_instr", 64'(bus.instr),    64'h0A4);
        check("pj_flush", 64'(flush_cnt),    64'(exp_flush(16'd2)));
        @(negedge clk);
        bus.instr_ready = 1'b0;

        // Reset asserted mid-S_WAIT; the stale response arrives after release.
        rsp_delay = 3;
        do_reset();
        wait_req(12'h001, "rs_req1");
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rsp_hold = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("rs_req",   64'(bus.imem_req),    64'd0);
        check("rs_valid", 64'(bus.instr_valid), 64'd0);
        check("rs_instr", {bus.instr, bus.instr_pc}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rs_first_req", {bus.imem_req, bus.imem_addr}, {1'b1, 12'h000});
        @(negedge clk);
        @(negedge clk);
        rsp_hold = 1'b0;
        wait_valid("rs_first_valid");
        check("rs_pc",    64'(bus.instr_pc), 64'h000);
        check("rs_instr", 64'(bus.instr),    64'd100);

        // Jump from S_IDLE to the top address, then wrap to zero.
        rsp_delay = 1;
        do_reset();
        bus.jump = 1'b1; bus.jump_target = 12'hFFF;
        @(posedge clk); #1;
        check("wr_req", {bus.imem_req, bus.imem_addr}, {1'b1, 12'hFFF});
        @(negedge clk);
        bus.jump = 1'b0;
        wait_req(12'h000, "wr_req_wrap");
        repeat (2) @(posedge clk);
        #1;
        check("wr_head", {bus.instr_valid, bus.instr_pc, bus.instr}, {1'b1, 12'hFFF, 19'h1063});
        @(negedge clk);
        bus.instr_ready = 1'b1;
        @(posedge clk); #1;
        check("wr_next", {bus.instr_valid, bus.instr_pc, bus.instr}, {1'b1, 12'h000, 19'd100});
        @(negedge clk);
        bus.instr_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
